wb_pipe_stage: RTL

WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

---
 rtl/wb_pipe_stage_pkg.sv | 32 +++
 rtl/wb_pipe_stage_load_align.sv | 54 +++++
 rtl/wb_pipe_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wb_pipe_stage_pkg.sv
// Shared types for the writeback stage: FSM states, load kinds, regfile source select.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    DROP
  } wb_state_t;

  typedef enum logic [2:0] {
    lb,
    lbu,
    lh,
    lhu,
    lw,
    lwu,
    ld
  } load_funct_t;

  // Prefixed so the literals never collide with the same-named datapath ports.
  typedef enum logic [2:0] {
    sel_alu_out,
    sel_br_en,
    sel_u_imm,
    sel_load,
    sel_pc_plus4
  } regfilemux_sel_t;

  // Wide enough for the largest legal TIMEOUT (65535).
  localparam int CNT_W = 16;

endpackage

// File: rtl/wb_pipe_stage_load_align.sv
// Combinational load lane extraction, sign/zero extension and alignment check.
module load_align
  import rv32i_types::*;
#(
  parameter  int XLEN = 32,
  localparam int OW   = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [OW-1:0]   off_i,
  input  load_funct_t     funct_i,
  output logic [XLEN-1:0] data_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] sh;

  // Bring the addressed byte lane down to bit 0.
  assign sh = rdata_i >> {off_i, 3'b000};

  // Extend per load kind; 64-bit-only kinds count as misaligned on a 32-bit datapath.
  always_comb begin
    data_o     = '0;
    misalign_o = 1'b0;
    case (funct_i)
      lb:  data_o = XLEN'($signed(sh[7:0]));
      lbu: data_o = XLEN'(sh[7:0]);
      lh: begin
        data_o     = XLEN'($signed(sh[15:0]));
        misalign_o = off_i[0];
      end
      lhu: begin
        data_o     = XLEN'(sh[15:0]);
        misalign_o = off_i[0];
      end
      lw: begin
        data_o     = XLEN'($signed(sh[31:0]));
        misalign_o = (off_i[1:0] != 2'b00);
      end
      lwu: begin
        data_o     = XLEN'(sh[31:0]);
        misalign_o = (XLEN != 64) || (off_i[1:0] != 2'b00);
      end
      ld: begin
        data_o     = sh;
        misalign_o = (XLEN != 64) || (off_i != '0);
      end
      default: begin
        data_o     = '0;
        misalign_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// Writeback stage: accepts one instruction from MEM, waits for load data if
// needed, and drives a registered regfile write port plus error pulses.
module wb_pipe_stage
  import rv32i_types::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] u_imm,
  input  logic            br_en,
  input  logic [4:0]      rd,
  input  regfilemux_sel_t regfilemux_sel,
  input  load_funct_t     load_funct,
  input  logic            dmem_resp,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            flush,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            misalign_o,
  output logic            timeout_o
);

  localparam int             OW       = $clog2(XLEN / 8);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  wb_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        hold_rd_q, hold_rd_d;
  load_funct_t       hold_funct_q, hold_funct_d;
  logic [OW-1:0]     hold_off_q, hold_off_d;
  logic              rf_we_q, rf_we_d, mis_q, mis_d, to_q, to_d;
  logic [4:0]        rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

  logic              wr;
  logic [XLEN-1:0]   wr_data, nl_data, ld_data;
  logic              ld_mis;
  logic [4:0]        rd_src;
  logic [OW-1:0]     off_src;
  load_funct_t       funct_src;

  assign ready_o    = (state_q == IDLE);
  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wdata   = rf_wdata_q;
  assign misalign_o = mis_q;
  assign timeout_o  = to_q;

  // In IDLE the instruction is still on the inputs; afterwards it lives in the hold register.
  assign rd_src    = ready_o ? rd                : hold_rd_q;
  assign off_src   = ready_o ? alu_out[OW-1:0]   : hold_off_q;
  assign funct_src = ready_o ? load_funct        : hold_funct_q;

  load_align #(.XLEN(XLEN)) u_align (
    .rdata_i    (dmem_rdata),
    .off_i      (off_src),
    .funct_i    (funct_src),
    .data_o     (ld_data),
    .misalign_o (ld_mis)
  );

  // Non-load result select.
  always_comb begin
    nl_data = '0;
    case (regfilemux_sel)
      sel_alu_out:  nl_data = alu_out;
      sel_br_en:    nl_data = XLEN'(br_en);
      sel_u_imm:    nl_data = u_imm;
      sel_pc_plus4: nl_data = pc + XLEN'(4);
      default:      nl_data = '0;
    endcase
  end

  // Next-state, hold capture and output pulse decisions.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_rd_d    = hold_rd_q;
    hold_funct_d = hold_funct_q;
    hold_off_d   = hold_off_q;
    rf_we_d      = 1'b0;
    mis_d        = 1'b0;
    to_d         = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wdata_d   = rf_wdata_q;
    wr           = 1'b0;
    wr_data      = ld_data;
    case (state_q)
      IDLE: begin
        // flush blocks the accept, so nothing from this cycle reaches the outputs.
        if (valid_i && !flush) begin
          hold_rd_d    = rd;
          hold_funct_d = load_funct;
          hold_off_d   = alu_out[OW-1:0];
          if (regfilemux_sel != sel_load) begin
            wr      = 1'b1;
            wr_data = nl_data;
          end else if (ld_mis) begin
            mis_d = 1'b1;
          end else if (dmem_resp) begin
            wr = 1'b1;
          end else begin
            state_d = WAIT_MEM;
            cnt_d   = '0;
          end
        end
      end
      WAIT_MEM: begin
        if (flush) begin
          // A response arriving with the flush is consumed here; otherwise DROP eats it later.
          state_d = dmem_resp ? IDLE : DROP;
        end else if (dmem_resp) begin
          wr      = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          to_d    = 1'b1;
          state_d = DROP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DROP: begin
        if (dmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wr) begin
      rf_rd_d    = rd_src;
      rf_wdata_d = wr_data;
      rf_we_d    = (rd_src != 5'd0);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_rd_q    <= '0;
      hold_funct_q <= lb;
      hold_off_q   <= '0;
      rf_we_q      <= 1'b0;
      mis_q        <= 1'b0;
      to_q         <= 1'b0;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_rd_q    <= hold_rd_d;
      hold_funct_q <= hold_funct_d;
      hold_off_q   <= hold_off_d;
      rf_we_q      <= rf_we_d;
      mis_q        <= mis_d;
      to_q         <= to_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

`ifndef SYNTHESIS
  // An out-of-range selector means the upstream decoder is broken; stop loudly.
  always_ff @(posedge clk) begin
    if (!rst && valid_i && ready_o && !flush) begin
      if (3'(regfilemux_sel) > 3'd4)
        $fatal(1, "wb_pipe_stage: illegal regfilemux_sel %0d", regfilemux_sel);
      if (regfilemux_sel == sel_load && 3'(load_funct) == 3'd7)
        $fatal(1, "wb_pipe_stage: illegal load_funct %0d", load_funct);
    end
  end
`endif

endmodule
